// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - byte-port arbiter between 32-bit fetch bursts and loader byte writes (optional IMEM_RANGE_CHECK_EN)
module imem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int MEM_AW          = 9,
    parameter int MEM_BYTES       = 512,
    parameter int LOADER_PRIORITY = 1
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddress,
    output logic              fetchReady,
    output logic              fetchValid,
    output logic [31:0]       instructionOut,
    input  logic              flush,
    input  logic              loadReq,
    input  logic [MEM_AW-1:0] loadAddr,
    input  logic [7:0]        loadData,
    output logic              loadAck,
    output logic [MEM_AW-1:0] memAddr,
    output logic              memWe,
    output logic [7:0]        memWdata,
`ifdef IMEM_RANGE_CHECK_EN
    output logic              fetchErr,
`endif
    input  logic [7:0]        memRdata
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, LOAD} state_t;

    state_t            state, stateNext;
    logic [MEM_AW-1:0] base;
    logic [1:0]        idx;
    logic [1:0]        idxNext;
    logic [23:0]       partial;
    logic              takeFetch, takeLoad, rangeErr;

`ifdef IMEM_RANGE_CHECK_EN
    assign rangeErr = (|fetchAddress[ADDR_W-1:MEM_AW]) ||
                      (({1'b0, fetchAddress[MEM_AW-1:0]} + (MEM_AW+1)'(3)) >= (MEM_AW+1)'(MEM_BYTES));
`else
    logic unused_hi;
    assign unused_hi = ^{fetchAddress[ADDR_W-1:MEM_AW], (MEM_BYTES == (1 << MEM_AW))};
    assign rangeErr  = 1'b0;
`endif

    assign fetchReady = (state == IDLE) && !flush;
    assign idxNext    = idx + 2'd1;

    always_comb begin
        takeFetch = 1'b0;
        takeLoad  = 1'b0;
        if (state == IDLE && !flush) begin
            if (fetchReq && loadReq) begin
                if (LOADER_PRIORITY != 0) takeLoad = 1'b1;
                else                      takeFetch = 1'b1;
            end else if (fetchReq) begin
                takeFetch = 1'b1;
            end else if (loadReq) begin
                takeLoad = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (takeLoad)                   stateNext = LOAD;
                else if (takeFetch && !rangeErr) stateNext = FETCH;
            end
            FETCH: begin
                if (flush)            stateNext = IDLE;
                else if (idx == 2'd3) stateNext = DRAIN;
            end
            DRAIN:   stateNext = IDLE;
            LOAD:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= stateNext;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fetchValid     <= 1'b0;
            loadAck        <= 1'b0;
            memWe          <= 1'b0;
            memAddr        <= '0;
            memWdata       <= '0;
            instructionOut <= '0;
            idx            <= '0;
            base           <= '0;
            partial        <= '0;
`ifdef IMEM_RANGE_CHECK_EN
            fetchErr       <= 1'b0;
`endif
        end else begin
            fetchValid <= 1'b0;
            loadAck    <= 1'b0;
            memWe      <= 1'b0;
`ifdef IMEM_RANGE_CHECK_EN
            fetchErr   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (takeLoad) begin
                        memAddr  <= loadAddr;
                        memWdata <= loadData;
                        memWe    <= 1'b1;
                        loadAck  <= 1'b1;
                    end else if (takeFetch) begin
                        if (rangeErr) begin
`ifdef IMEM_RANGE_CHECK_EN
                            fetchErr <= 1'b1;
`endif
                        end else begin
                            base    <= fetchAddress[MEM_AW-1:0];
                            memAddr <= fetchAddress[MEM_AW-1:0];
                            idx     <= 2'd0;
                        end
                    end
                end
                FETCH: begin
                    if (!flush) begin
                        // memRdata lags memAddr by one cycle, so slot idx-1 lands now
                        case (idx)
                            2'd1:    partial[23:16] <= memRdata;
                            2'd2:    partial[15:8]  <= memRdata;
                            2'd3:    partial[7:0]   <= memRdata;
                            default: ;
                        endcase
                        idx <= idxNext;
                        if (idx != 2'd3) memAddr <= base + MEM_AW'(idxNext);
                    end
                end
                DRAIN: begin
                    if (!flush) begin
                        instructionOut <= {partial, memRdata};
                        fetchValid     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed bench for imem_port_arbiter (both loader priorities)
module tb_imem_port_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    int          n_cmp = 0;
    int          n_err = 0;

    // instance with LOADER_PRIORITY=1
    logic        fetchReq, flush, loadReq;
    logic [31:0] fetchAddress;
    logic [8:0]  loadAddr;
    logic [7:0]  loadData;
    logic        fetchReady, fetchValid, loadAck, memWe;
    logic [31:0] instructionOut;
    logic [8:0]  memAddr;
    logic [7:0]  memWdata, memRdata;
    logic [7:0]  mem1 [0:511];

    // instance with LOADER_PRIORITY=0
    logic        fetchReqB, flushB, loadReqB;
    logic [31:0] fetchAddressB;
    logic [8:0]  loadAddrB;
    logic [7:0]  loadDataB;
    logic        fetchReadyB, fetchValidB, loadAckB, memWeB;
    logic [31:0] instructionOutB;
    logic [8:0]  memAddrB;
    logic [7:0]  memWdataB, memRdataB;
    logic [7:0]  mem0 [0:511];

`ifdef IMEM_RANGE_CHECK_EN
    logic        fetchErr, fetchErrB;
`endif

    always #5 clock = ~clock;

    imem_port_arbiter #(.LOADER_PRIORITY(1)) dut (
        .clock(clock), .resetN(resetN),
        .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchReady(fetchReady),
        .fetchValid(fetchValid), .instructionOut(instructionOut), .flush(flush),
        .loadReq(loadReq), .loadAddr(loadAddr), .loadData(loadData), .loadAck(loadAck),
        .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata),
`ifdef IMEM_RANGE_CHECK_EN
        .fetchErr(fetchErr),
`endif
        .memRdata(memRdata)
    );

    imem_port_arbiter #(.LOADER_PRIORITY(0)) dut0 (
        .clock(clock), .resetN(resetN),
        .fetchReq(fetchReqB), .fetchAddress(fetchAddressB), .fetchReady(fetchReadyB),
        .fetchValid(fetchValidB), .instructionOut(instructionOutB), .flush(flushB),
        .loadReq(loadReqB), .loadAddr(loadAddrB), .loadData(loadDataB), .loadAck(loadAckB),
        .memAddr(memAddrB), .memWe(memWeB), .memWdata(memWdataB),
`ifdef IMEM_RANGE_CHECK_EN
        .fetchErr(fetchErrB),
`endif
        .memRdata(memRdataB)
    );

    always @(posedge clock) begin
        if (memWe) mem1[memAddr] <= memWdata;
        memRdata <= mem1[memAddr];
        if (memWeB) mem0[memAddrB] <= memWdataB;
        memRdataB <= mem0[memAddrB];
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // accept at edge T, expect memAddr addr..addr+3 in cycles T..T+3, fetchValid in T+5
    task automatic fetch1(input logic [31:0] addr, input logic [31:0] word);
        logic [8:0] a;
        fetchReq     = 1'b1;
        fetchAddress = addr;
        tick();
        fetchReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = addr[8:0] + 9'(k);
            check_value("fetch_addr", 32'(memAddr), 32'(a));
            if (k < 3) tick();
        end
        tick();
        check_value("valid_t4", 32'(fetchValid), 32'd0);
        tick();
        check_value("valid_t5", 32'(fetchValid), 32'd1);
        check_value("word", instructionOut, word);
        tick();
        check_value("valid_pulse", 32'(fetchValid), 32'd0);
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 512; i++) begin
            mem1[i] = 8'(i) ^ 8'h3C;
            mem0[i] = 8'(i) ^ 8'h3C;
        end
        mem1[8] = 8'h20; mem1[9] = 8'h08; mem1[10] = 8'h00; mem1[11] = 8'h05;
        resetN = 1'b0;
        fetchReq = 0; flush = 0; loadReq = 0; fetchAddress = 0; loadAddr = 0; loadData = 0;
        fetchReqB = 0; flushB = 0; loadReqB = 0; fetchAddressB = 0; loadAddrB = 0; loadDataB = 0;

        tick();
        check_value("rst_memaddr", 32'(memAddr), 32'd0);
        check_value("rst_memwe", 32'(memWe), 32'd0);
        check_value("rst_loadack", 32'(loadAck), 32'd0);
        check_value("rst_valid", 32'(fetchValid), 32'd0);
        check_value("rst_instr", instructionOut, 32'd0);
        resetN = 1'b1;
        tick();
        check_value("rst_ready", 32'(fetchReady), 32'd1);

        fetch1(32'd8, 32'h20080005);

        loadReq = 1'b1; loadAddr = 9'd100; loadData = 8'hAB;
        tick();
        loadReq = 1'b0;
        check_value("load_ack", 32'(loadAck), 32'd1);
        check_value("load_we", 32'(memWe), 32'd1);
        check_value("load_addr", 32'(memAddr), 32'd100);
        check_value("load_data", 32'(memWdata), 32'hAB);
        tick();
        check_value("load_ack_end", 32'(loadAck), 32'd0);
        check_value("load_we_end", 32'(memWe), 32'd0);
        fetch1(32'd100, 32'hAB595A5B);

        // simultaneous requests, loader first
        fetchReq = 1'b1; fetchAddress = 32'd8;
        loadReq = 1'b1; loadAddr = 9'd200; loadData = 8'h77;
        tick();
        loadReq = 1'b0;
        check_value("p1_loadack", 32'(loadAck), 32'd1);
        check_value("p1_loadaddr", 32'(memAddr), 32'd200);
        tick();
        check_value("p1_loadack_end", 32'(loadAck), 32'd0);
        tick();
        fetchReq = 1'b0;
        check_value("p1_fetch_addr", 32'(memAddr), 32'd8);
        for (int k = 0; k < 5; k++) tick();
        check_value("p1_valid", 32'(fetchValid), 32'd1);
        check_value("p1_word", instructionOut, 32'h20080005);

        // simultaneous requests, fetch first
        fetchReqB = 1'b1; fetchAddressB = 32'd8;
        loadReqB = 1'b1; loadAddrB = 9'd300; loadDataB = 8'h11;
        tick();
        fetchReqB = 1'b0;
        check_value("p0_loadack", 32'(loadAckB), 32'd0);
        check_value("p0_fetch_addr", 32'(memAddrB), 32'd8);
        for (int k = 0; k < 5; k++) tick();
        check_value("p0_valid", 32'(fetchValidB), 32'd1);
        check_value("p0_word", instructionOutB, 32'h34353637);
        check_value("p0_loadack_t5", 32'(loadAckB), 32'd0);
        tick();
        loadReqB = 1'b0;
        check_value("p0_loadack_t6", 32'(loadAckB), 32'd1);
        check_value("p0_loadaddr", 32'(memAddrB), 32'd300);
        check_value("p0_we", 32'(memWeB), 32'd1);
        tick();
        check_value("p0_loadack_end", 32'(loadAckB), 32'd0);

        // flush mid-burst
        fetchReq = 1'b1; fetchAddress = 32'd0;
        tick();
        fetchReq = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        check_value("flush_ready_low", 32'(fetchReady), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check_value("flush_idle", 32'(fetchReady), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | fetchValid;
        end
        check_value("flush_no_valid", 32'(seen), 32'd0);
        check_value("flush_keep_word", instructionOut, 32'h20080005);
        fetch1(32'd4, 32'h38393A3B);

        // flush in IDLE blocks acceptance
        flush = 1'b1; fetchReq = 1'b1; fetchAddress = 32'd8;
        tick();
        check_value("idle_flush_ready", 32'(fetchReady), 32'd0);
        check_value("idle_flush_addr", 32'(memAddr), 32'd7);
        fetchReq = 1'b0; flush = 1'b0;
        tick();
        check_value("idle_flush_addr2", 32'(memAddr), 32'd7);

`ifdef IMEM_RANGE_CHECK_EN
        fetchReq = 1'b1; fetchAddress = 32'd510;
        tick();
        fetchReq = 1'b0;
        check_value("err_pulse", 32'(fetchErr), 32'd1);
        check_value("err_addr", 32'(memAddr), 32'd7);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | fetchValid;
        end
        check_value("err_no_valid", 32'(seen), 32'd0);
        check_value("err_keep_word", instructionOut, 32'h38393A3B);
`else
        fetch1(32'd510, 32'hC2C33C3D);
        fetch1(32'h0001_0008, 32'h20080005);
`endif

        // reset mid-burst
        fetchReq = 1'b1; fetchAddress = 32'd8;
        tick();
        fetchReq = 1'b0;
        tick(); tick(); tick();
        resetN = 1'b0;
        #1;
        check_value("mid_rst_addr", 32'(memAddr), 32'd0);
        check_value("mid_rst_instr", instructionOut, 32'd0);
        check_value("mid_rst_valid", 32'(fetchValid), 32'd0);
        check_value("mid_rst_we", 32'(memWe), 32'd0);
        tick();
        resetN = 1'b1;
        #1;
        check_value("mid_rst_ready", 32'(fetchReady), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | fetchValid;
        end
        check_value("mid_rst_no_valid", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
